clk_fwd_gen: RTL and testbench
==============================

# clk_fwd_gen

Parametrised multi-channel clock forwarder for sensor/LVDS clock outputs. It generates a per-channel forwarded clock from the fabric clock. The output is either full-rate (DDR-register pass-through) or divided by an even ratio. Each channel supports glitch-free start/stop and a counted-burst mode for sensor readout sequencing. It sits between the sensor control FSM and the output pins, and drives each pin through a DDR output register.

## Interface

Parameters:
- NUM_CH, 2: number of independent forwarded-clock channels.
- DIV_W, 8: width of the per-channel half-period field.
- CNT_W, 16: width of the per-channel burst-length field.

Ports:
- clk  in  1  fabric clock; all logic and the DDR registers run on it.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_div  in  NUM_CH*DIV_W  half-period per channel, in clk cycles; 0 = full-rate.
- cfg_burst  in  NUM_CH  mode per channel: 0 = continuous, 1 = burst.
- cfg_len  in  NUM_CH*CNT_W  pulses per burst, per channel.
- ch_en  in  NUM_CH  level enable per channel; low requests a graceful stop or abort.
- start  in  NUM_CH  one-cycle burst trigger per channel.
- busy  out  NUM_CH  channel not IDLE.
- done  out  NUM_CH  one-cycle pulse when a burst completes normally.
- clk_out  out  NUM_CH  forwarded clock, driven from the DDR output register.

## Operation

- Each channel has one FSM with states IDLE, RUN and STOP.
- In IDLE:
  - Continuous mode: ch_en=1 moves the channel to RUN.
  - Burst mode: start=1 with ch_en=1 moves the channel to RUN.
  - cfg_div, cfg_burst and cfg_len are latched on the IDLE exit. Changes made in RUN or STOP are ignored.
- Output levels, as the (d0, d1) pair fed to the DDR register:
  - IDLE: (0, 0).
  - div=0 in RUN: (1, 0), so clk_out follows clk. Each clk cycle is one pulse.
  - div=N≥1: (1, 1) for N cycles, then (0, 0) for N cycles. The period is 2N clk cycles and the duty cycle is exactly 50%.
- Phase counter:
  - Width DIV_W. It resets to 0 on RUN entry, so the high phase comes first.
  - It wraps at N-1 and toggles the level on each wrap.
- Continuous stop: ch_en=0 in RUN moves the channel to STOP.
  - In the high phase, the full high phase completes; the channel then goes to IDLE on the cycle the output would go low.
  - In the low phase, the channel goes to IDLE immediately.
  - A high phase is never truncated.
- Burst:
  - The pulse counter (CNT_W) increments at the end of each high phase.
  - When the count reaches cfg_len, the channel goes to IDLE and done pulses in the same cycle.
  - cfg_len=0: the channel goes to IDLE one cycle after start. done pulses, and no high level is emitted.
- Burst abort: ch_en=0 during a burst follows the STOP rule, and done is not asserted.
- start while busy is ignored. start in continuous mode is ignored.
- ch_en=1 in STOP does not cancel the stop. The channel restarts only from IDLE.
- Channels are fully independent. Channels started in the same cycle with equal cfg_div stay phase-aligned indefinitely.

## Timing

- Reset values: busy=0, done=0, d0=d1=0, clk_out=0. All FSMs are in IDLE and all counters are 0.
- Reset asserted mid-run forces clk_out low immediately. A runt pulse is accepted in this case.
- ch_en or start sampled high at edge k:
  - busy=1 from edge k+1.
  - d0/d1 are registered at edge k+1.
  - clk_out first rises at edge k+2 (one DDR-register cycle).
- End of run:
  - busy falls on the edge that enters IDLE.
  - done is registered and is high for exactly the cycle in which busy first reads 0.
- The d0/d1 → clk_out relationship is a fixed one-cycle latency on every channel.

## Structure

- Shared package clk_fwd_pkg:
  - State encoding constants ST_IDLE, ST_RUN, ST_STOP.
  - Mode constants MODE_CONT and MODE_BURST.
  - Level-pair constants LVL_LOW (0,0), LVL_HIGH (1,1) and LVL_PASS (1,0).
- Sub-module clk_fwd_oddr: one DDR output register per channel, instantiated in a generate loop.
  - C0=clk, C1=~clk, CE=1, D0/D1 from the FSM.
  - Sync set/reset tied off, INIT=0, alignment NONE.
- FSM and counters sit in a per-channel generate block in the top level.

## Test plan

- div=0, continuous, ch_en high for 20 cycles then low → clk_out mirrors clk for 20 cycles starting 2 cycles after enable. busy is high 20 cycles and done never pulses.
- div=3, continuous, ch_en dropped on the 2nd cycle of a high phase → the high phase still lasts 3 cycles, then clk_out stays low and busy falls on the same edge the output goes low.
- div=2, burst, cfg_len=5, start pulse → exactly 5 high pulses of 2 cycles, period 4. done pulses once, busy has fallen, and a second start during the burst is ignored.
- Burst with cfg_len=0 → busy high for 1 cycle, done pulses, and clk_out stays 0. Burst with ch_en dropped after 2 of 5 pulses → 2 complete pulses and no done.
- Ch0 div=1 and ch1 div=4 started in the same cycle, with cfg_div changed mid-run → each keeps its latched period (2 and 8 cycles) and they run independently.
- rst_n pulsed low mid-high-phase → clk_out, busy and done go to 0 asynchronously. The FSM is in IDLE after release, and it restarts only on a new ch_en or start.

Source files
------------

// File: rtl/clk_fwd_pkg.sv
// Shared encodings for the forwarded-clock generator.
// Holds state, mode and DDR level-pair constants.
package clk_fwd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    // Level pair is {d0, d1}: d0 shown while clk is high, d1 while clk is low.
    typedef logic [1:0] lvl_t;
    localparam lvl_t LVL_LOW  = 2'b00;
    localparam lvl_t LVL_HIGH = 2'b11;
    localparam lvl_t LVL_PASS = 2'b10;

endpackage

// File: rtl/clk_fwd_oddr.sv
// DDR output register: d0/d1 captured on c0 rise, d1 replayed on c1 rise; 1 cycle latency.
// No backpressure; async reset forces q low immediately.
module clk_fwd_oddr #(
    parameter bit INIT = 1'b0
) (
    input  logic c0,
    input  logic c1,
    input  logic ce,
    input  logic d0,
    input  logic d1,
    input  logic sr,
    input  logic rst_n,
    output logic q
);

    logic rise_q, rise_d;
    logic hold_q, hold_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = rise_q;
        hold_d = hold_q;
        fall_d = fall_q;
        if (sr) begin
            rise_d = INIT;
            hold_d = INIT;
            fall_d = INIT;
        end else if (ce) begin
            rise_d = d0;
            hold_d = d1;
            fall_d = hold_q;
        end
    end

    // d1 is taken on the same rising edge as d0 so each pair leaves as one cycle.
    always_ff @(posedge c0 or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= INIT;
            hold_q <= INIT;
        end else begin
            rise_q <= rise_d;
            hold_q <= hold_d;
        end
    end

    always_ff @(posedge c1 or negedge rst_n) begin
        if (!rst_n) fall_q <= INIT;
        else        fall_q <= fall_d;
    end

    assign q = c0 ? rise_q : fall_q;

endmodule

// File: rtl/clk_fwd_gen.sv
// Per-channel forwarded clock (full-rate or /2N) with glitch-free stop and counted bursts.
// Latency: enable at edge k -> busy k+1 -> clk_out rises k+2; no backpressure.
module clk_fwd_gen
    import clk_fwd_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DIV_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0]        cfg_burst,
    input  logic [NUM_CH*CNT_W-1:0]  cfg_len,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        start,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH-1:0]        clk_out
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           st_q, st_d;
        logic [DIV_W-1:0] div_q, div_d, ph_q, ph_d;
        logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
        logic             mode_q, mode_d, hi_q, hi_d, done_q, done_d;
        lvl_t             lvl_q, lvl_d;
        logic [DIV_W-1:0] cfg_div_c;
        logic [CNT_W-1:0] cfg_len_c, cnt_inc;
        logic             go, wrap, last;

        assign cfg_div_c = cfg_div[c*DIV_W +: DIV_W];
        assign cfg_len_c = cfg_len[c*CNT_W +: CNT_W];
        assign go        = ch_en[c] && (cfg_burst[c] == MODE_CONT || start[c]);
        assign wrap      = (ph_q == div_q - DIV_W'(1));
        assign cnt_inc   = cnt_q + CNT_W'(1);
        assign last      = (mode_q == MODE_BURST) && (cnt_inc == len_q);

        always_comb begin
            st_d   = st_q;
            div_d  = div_q;
            len_d  = len_q;
            mode_d = mode_q;
            ph_d   = ph_q;
            cnt_d  = cnt_q;
            hi_d   = hi_q;
            done_d = 1'b0;
            lvl_d  = LVL_LOW;
            case (st_q)
                ST_IDLE: if (go) begin
                    st_d   = ST_RUN;
                    div_d  = cfg_div_c;
                    len_d  = cfg_len_c;
                    mode_d = cfg_burst[c];
                    ph_d   = '0;
                    cnt_d  = '0;
                    hi_d   = 1'b1;
                    if (cfg_burst[c] == MODE_BURST && cfg_len_c == '0) lvl_d = LVL_LOW;
                    else if (cfg_div_c == '0)                          lvl_d = LVL_PASS;
                    else                                               lvl_d = LVL_HIGH;
                end
                ST_RUN: begin
                    if (mode_q == MODE_BURST && len_q == '0) begin
                        st_d   = ST_IDLE;
                        done_d = 1'b1;
                    end else if (div_q == '0) begin
                        if (!ch_en[c]) st_d = ST_IDLE;
                        else if (last) begin
                            st_d   = ST_IDLE;
                            done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                            lvl_d = LVL_PASS;
                        end
                    end else if (!hi_q) begin
                        // A low phase can be cut short: the pin is already low.
                        if (!ch_en[c]) st_d = ST_IDLE;
                        else if (wrap) begin
                            ph_d  = '0;
                            hi_d  = 1'b1;
                            lvl_d = LVL_HIGH;
                        end else begin
                            ph_d = ph_q + DIV_W'(1);
                        end
                    end else if (wrap) begin
                        if (!ch_en[c]) st_d = ST_IDLE;
                        else if (last) begin
                            st_d   = ST_IDLE;
                            done_d = 1'b1;
                        end else begin
                            ph_d  = '0;
                            hi_d  = 1'b0;
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        ph_d  = ph_q + DIV_W'(1);
                        lvl_d = LVL_HIGH;
                        if (!ch_en[c]) st_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (wrap) st_d = ST_IDLE;
                    else begin
                        ph_d  = ph_q + DIV_W'(1);
                        lvl_d = LVL_HIGH;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= ST_IDLE;
                div_q  <= '0;
                len_q  <= '0;
                mode_q <= MODE_CONT;
                ph_q   <= '0;
                cnt_q  <= '0;
                hi_q   <= 1'b0;
                done_q <= 1'b0;
                lvl_q  <= LVL_LOW;
            end else begin
                st_q   <= st_d;
                div_q  <= div_d;
                len_q  <= len_d;
                mode_q <= mode_d;
                ph_q   <= ph_d;
                cnt_q  <= cnt_d;
                hi_q   <= hi_d;
                done_q <= done_d;
                lvl_q  <= lvl_d;
            end
        end

        assign busy[c] = (st_q != ST_IDLE);
        assign done[c] = done_q;

        clk_fwd_oddr #(.INIT(1'b0)) u_oddr (
            .c0    (clk),
            .c1    (~clk),
            .ce    (1'b1),
            .d0    (lvl_q[1]),
            .d1    (lvl_q[0]),
            .sr    (1'b0),
            .rst_n (rst_n),
            .q     (clk_out[c])
        );
    end

endmodule

// File: tb/tb_clk_fwd_gen.sv
// Randomised and directed bench for clk_fwd_gen against a phase-arithmetic reference model.
module tb_clk_fwd_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
    logic [NUM_CH-1:0]       cfg_burst = '0;
    logic [NUM_CH*CNT_W-1:0] cfg_len = '0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       busy, done, clk_out;

    always #5 clk = ~clk;

    clk_fwd_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
        .cfg_len(cfg_len), .ch_en(ch_en), .start(start),
        .busy(busy), .done(done), .clk_out(clk_out)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: a run is described by its cycle index since entry; levels follow
    // directly from t / div arithmetic.
    bit m_act [NUM_CH];
    bit m_burst [NUM_CH];
    bit m_stop [NUM_CH];
    bit m_done [NUM_CH];
    int m_t [NUM_CH];
    int m_div [NUM_CH];
    int m_len [NUM_CH];
    int hi_cnt [NUM_CH];
    int busy_cnt [NUM_CH];
    int done_cnt [NUM_CH];

    function automatic logic [1:0] exp_lvl(input int c);
        if (!m_act[c])                  return 2'b00;
        if (m_burst[c] && m_len[c] == 0) return 2'b00;
        if (m_div[c] == 0)              return 2'b10;
        return ((m_t[c] / m_div[c]) % 2 == 0) ? 2'b11 : 2'b00;
    endfunction

    task automatic model_edge(input int c);
        bit en, st, hn, hx;
        int tn;
        en = ch_en[c];
        st = start[c];
        m_done[c] = 1'b0;
        tn = m_t[c] + 1;
        if (!m_act[c]) begin
            if (en && (!cfg_burst[c] || st)) begin
                m_act[c]   = 1'b1;
                m_t[c]     = 0;
                m_stop[c]  = 1'b0;
                m_div[c]   = int'(cfg_div[c*DIV_W +: DIV_W]);
                m_len[c]   = int'(cfg_len[c*CNT_W +: CNT_W]);
                m_burst[c] = cfg_burst[c];
            end
        end else if (m_burst[c] && m_len[c] == 0) begin
            m_act[c]  = 1'b0;
            m_done[c] = 1'b1;
        end else if (m_div[c] == 0) begin
            if (!en) m_act[c] = 1'b0;
            else if (m_burst[c] && tn == m_len[c]) begin
                m_act[c]  = 1'b0;
                m_done[c] = 1'b1;
            end else m_t[c] = tn;
        end else begin
            hn = ((m_t[c] / m_div[c]) % 2 == 0);
            hx = ((tn / m_div[c]) % 2 == 0);
            if (m_stop[c]) begin
                if (!hx) m_act[c] = 1'b0;
                else     m_t[c] = tn;
            end else if (!en) begin
                if (!hn || !hx) m_act[c] = 1'b0;
                else begin
                    m_stop[c] = 1'b1;
                    m_t[c]    = tn;
                end
            end else if (m_burst[c] && hn && !hx && (tn / m_div[c] + 1) / 2 == m_len[c]) begin
                m_act[c]  = 1'b0;
                m_done[c] = 1'b1;
            end else m_t[c] = tn;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c]  = 1'b0;
            m_done[c] = 1'b0;
            m_stop[c] = 1'b0;
        end
    endtask

    // One clock: model update at the edge, then check both halves of the cycle.
    task automatic step();
        logic [1:0] pin [NUM_CH];
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            pin[c] = exp_lvl(c);
            model_edge(c);
        end
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_act[c]));
            chk($sformatf("done%0d", c), 32'(done[c]), 32'(m_done[c]));
            chk($sformatf("clk_out_hi%0d", c), 32'(clk_out[c]), 32'(pin[c][1]));
            if (clk_out[c]) hi_cnt[c]++;
            if (busy[c])    busy_cnt[c]++;
            if (done[c])    done_cnt[c]++;
        end
        @(negedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("clk_out_lo%0d", c), 32'(clk_out[c]), 32'(pin[c][0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < NUM_CH; c++) begin
            hi_cnt[c] = 0;
            busy_cnt[c] = 0;
            done_cnt[c] = 0;
        end
    endtask

    task automatic set_cfg(input int c, input int dv, input bit bm, input int ln);
        cfg_div[c*DIV_W +: DIV_W] = DIV_W'(dv);
        cfg_burst[c]              = bm;
        cfg_len[c*CNT_W +: CNT_W] = CNT_W'(ln);
    endtask

    task automatic expect_cnt(input string tag, input int c, input int hi, input int bz, input int dn);
        chk({tag, "_high_cycles"}, 32'(hi_cnt[c]), 32'(hi));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt[c]), 32'(bz));
        chk({tag, "_done_pulses"}, 32'(done_cnt[c]), 32'(dn));
    endtask

    initial begin
        bit found;
        model_reset();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // full-rate continuous: 20 enabled cycles give 20 pulses
        set_cfg(0, 0, 1'b0, 0);
        clr_cnt();
        ch_en[0] = 1'b1;
        run(20);
        ch_en[0] = 1'b0;
        run(5);
        expect_cnt("div0_cont", 0, 20, 20, 0);

        // div=3, enable dropped on the 2nd cycle of the second high phase
        set_cfg(0, 3, 1'b0, 0);
        clr_cnt();
        ch_en[0] = 1'b1;
        run(8);
        ch_en[0] = 1'b0;
        run(6);
        expect_cnt("div3_stop", 0, 6, 9, 0);

        // div=2 burst of 5, with a re-start while busy
        set_cfg(0, 2, 1'b1, 5);
        clr_cnt();
        ch_en[0] = 1'b1;
        start[0] = 1'b1;
        run(1);
        start[0] = 1'b0;
        run(3);
        start[0] = 1'b1;
        run(1);
        start[0] = 1'b0;
        run(25);
        expect_cnt("burst5", 0, 10, 18, 1);

        // zero-length burst
        set_cfg(0, 1, 1'b1, 0);
        clr_cnt();
        start[0] = 1'b1;
        run(1);
        start[0] = 1'b0;
        run(4);
        expect_cnt("burst0", 0, 0, 1, 1);

        // burst aborted in the low phase after two pulses
        set_cfg(0, 2, 1'b1, 5);
        clr_cnt();
        start[0] = 1'b1;
        run(1);
        start[0] = 1'b0;
        run(6);
        ch_en[0] = 1'b0;
        run(5);
        expect_cnt("abort", 0, 4, 7, 0);

        // two channels with different divisors, config changed mid-run
        set_cfg(0, 1, 1'b0, 0);
        set_cfg(1, 4, 1'b0, 0);
        clr_cnt();
        ch_en = 2'b11;
        run(1);
        set_cfg(0, 5, 1'b0, 0);
        set_cfg(1, 2, 1'b0, 0);
        run(15);
        chk("dual_ch0_high_cycles", 32'(hi_cnt[0]), 32'd8);
        chk("dual_ch1_high_cycles", 32'(hi_cnt[1]), 32'd8);
        ch_en = 2'b00;
        run(10);

        // async reset in the middle of a high phase
        set_cfg(0, 3, 1'b0, 0);
        ch_en[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = clk_out[0];
        end
        chk("rst_find_high", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        model_reset();
        ch_en = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clr_cnt();
        run(4);
        chk("post_rst_idle", 32'(busy_cnt[0]), 32'd0);
        ch_en[0] = 1'b1;
        run(8);
        ch_en[0] = 1'b0;
        run(6);

        // randomised traffic with occasional config churn
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
                start[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0)
                    set_cfg(c, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 6)));
            end
            step();
        end
        ch_en = '0;
        start = '0;
        run(20);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
